sprite_line_sched: RTL and testbench

Sequencer that shares the single 8-bit sprite ROM port among NUM_SPR hardware sprites. During each horizontal blanking interval it fetches the next scanline's row of every visible sprite into a double-buffered line store. During active video it composites the stored rows into one RGB 3/3/2 pixel stream for the VGA output stage. It sits between vga_controller (hc/vc/blank timing) and the sprite ROM, replacing per-sprite direct ROM addressing.

---
 rtl/sprite_line_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_sprite_line_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_sched.sv
// sprite_line_sched
// Shares the single 8-bit sprite ROM port among NUM_SPR sprite slots. During
// each hblank the FSM fetches the next scanline's row of every visible sprite
// into the fill bank of a double-buffered line store. During active video the
// display bank is composited into one RGB 3/3/2 pixel stream, one cycle late.
// Slot 0 has the highest priority. Byte 8'h00 is transparent.
//
// Optional feature macro: SPR_HFLIP_EN adds the spr_flip input. A slot with
// its flip bit set at CHECK has its row stored mirrored.
module sprite_line_sched #(
    parameter int NUM_SPR    = 4,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int ROM_STRIDE = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_start,
    input  logic [10:0]             next_vc,
    input  logic [10:0]             hc,
    input  logic                    blank,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [11*NUM_SPR-1:0]   spr_x,
    input  logic [11*NUM_SPR-1:0]   spr_y,
    input  logic [16*NUM_SPR-1:0]   spr_base,
`ifdef SPR_HFLIP_EN
    input  logic [NUM_SPR-1:0]      spr_flip,
`endif
    output logic [15:0]             rom_addr,
    output logic                    rom_en,
    input  logic [7:0]              mem_value,
    output logic [2:0]              R,
    output logic [2:0]              G,
    output logic [1:0]              B,
    output logic                    fetch_busy,
    output logic                    overrun
);

    localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        DRAIN,
        NEXT
    } state_t;

    state_t                     state;
    logic [SLOT_W-1:0]          slot;
    logic [COL_W-1:0]           col;
    logic [10:0]                next_vc_q;
    logic                       disp_bank;
    logic [1:0][NUM_SPR-1:0]    row_valid;

    // Capture pipeline: mirrors rom_en/col one cycle later, when the ROM byte
    // for that column is on mem_value.
    logic                       cap_en;
    logic [COL_W-1:0]           cap_col;
    logic [COL_W-1:0]           store_col;

`ifdef SPR_HFLIP_EN
    logic                       flip_q;
    logic                       flip_s;
    assign flip_s = spr_flip[slot];
`endif

    // Line store: [bank][slot][column]
    logic [7:0] line_mem [2][NUM_SPR][SPR_W];

    // Per-slot CHECK terms for the slot currently being considered
    logic [10:0]      spr_y_s;
    logic [15:0]      base_s;
    logic             slot_hit;
    logic [ROW_W-1:0] row_c;
    logic [15:0]      start_addr;

    // Visibility test and first ROM address of the selected slot's row
    always_comb begin
        spr_y_s    = spr_y[int'(slot)*11 +: 11];
        base_s     = spr_base[int'(slot)*16 +: 16];
        // The 12-bit sum keeps spr_y+SPR_H from wrapping past line 2047.
        slot_hit   = spr_en[slot]
                   && (next_vc_q >= spr_y_s)
                   && ({1'b0, next_vc_q} < ({1'b0, spr_y_s} + 12'(SPR_H)));
        row_c      = ROW_W'(next_vc_q - spr_y_s);
        start_addr = base_s + 16'(32'(row_c) * ROM_STRIDE);
    end

    // Fetch sequencer: bank swap on line_start, then CHECK/FETCH/DRAIN/NEXT per slot
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all state advances together on
        // the edge; a blocking = would let later statements see new values.
        if (rst) begin
            state      <= IDLE;
            slot       <= '0;
            col        <= '0;
            next_vc_q  <= '0;
            disp_bank  <= 1'b0;
            row_valid  <= '0;
            rom_addr   <= '0;
            rom_en     <= 1'b0;
            fetch_busy <= 1'b0;
            overrun    <= 1'b0;
            cap_en     <= 1'b0;
            cap_col    <= '0;
`ifdef SPR_HFLIP_EN
            flip_q     <= 1'b0;
`endif
        end else if (line_start) begin
            // A line_start outside IDLE (including the DRAIN cycle) abandons
            // the slot in flight; its row_valid bit is never set.
            if (state != IDLE) begin
                overrun <= 1'b1;
            end
            disp_bank            <= ~disp_bank;
            next_vc_q            <= next_vc;
            row_valid[disp_bank] <= '0;   // old display bank is the new fill bank
            state                <= CHECK;
            slot                 <= '0;
            rom_en               <= 1'b0;
            fetch_busy           <= 1'b1;
            cap_en               <= 1'b0;
        end else begin
            cap_en  <= rom_en;
            cap_col <= col;
            case (state)
                IDLE: begin
                    fetch_busy <= 1'b0;
                end
                CHECK: begin
                    if (slot_hit) begin
                        state    <= FETCH;
                        col      <= '0;
                        rom_en   <= 1'b1;
                        rom_addr <= start_addr;
`ifdef SPR_HFLIP_EN
                        flip_q   <= flip_s;
`endif
                    end else begin
                        state <= NEXT;
                    end
                end
                FETCH: begin
                    if (col == COL_W'(SPR_W - 1)) begin
                        rom_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        col      <= col + 1'b1;
                        rom_addr <= rom_addr + 16'd1;
                    end
                end
                DRAIN: begin
                    // The last byte is written at this same edge.
                    row_valid[~disp_bank][slot] <= 1'b1;
                    state                       <= NEXT;
                end
                NEXT: begin
                    if (slot == SLOT_W'(NUM_SPR - 1)) begin
                        state      <= IDLE;
                        fetch_busy <= 1'b0;
                    end else begin
                        slot  <= slot + 1'b1;
                        state <= CHECK;
                    end
                end
                default: begin
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

    // Column in the line store where the captured byte lands
    always_comb begin
`ifdef SPR_HFLIP_EN
        store_col = flip_q ? (COL_W'(SPR_W - 1) - cap_col) : cap_col;
`else
        store_col = cap_col;
`endif
    end

    // Line store write port: ROM byte into the fill bank for the active slot
    always_ff @(posedge clk) begin
        // NOTE: the line store has no reset; row_valid alone decides whether
        // a row is shown, so its byte contents never need clearing.
        if (cap_en && !line_start) begin
            line_mem[~disp_bank][slot][store_col] <= mem_value;
        end
    end

    logic [10:0]      x_s;
    logic [COL_W-1:0] x_col;
    logic [7:0]       byte_s;
    logic [7:0]       pix_c;

    // Compositor: walk slots from lowest priority up so slot 0 overwrites last
    always_comb begin
        pix_c  = 8'h00;
        x_s    = '0;
        x_col  = '0;
        byte_s = 8'h00;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            x_s    = spr_x[i*11 +: 11];
            x_col  = COL_W'(hc - x_s);
            byte_s = line_mem[disp_bank][i][x_col];
            if (row_valid[disp_bank][i]
                && (hc >= x_s)
                && ({1'b0, hc} < ({1'b0, x_s} + 12'(SPR_W)))
                && (byte_s != 8'h00)) begin
                pix_c = byte_s;
            end
        end
    end

    // Registered pixel output, forced black during blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            {R, G, B} <= 8'h00;
        end else if (blank) begin
            {R, G, B} <= 8'h00;
        end else begin
            {R, G, B} <= pix_c;
        end
    end

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched (default build, no horizontal flip).
// A behavioural ROM answers one cycle after rom_en; expected pixels are
// hand-computed from the ROM contents and sprite placement.
module tb_sprite_line_sched;

    localparam int NUM_SPR = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_start;
    logic [10:0]  next_vc;
    logic [10:0]  hc;
    logic         blank;
    logic [3:0]   spr_en;
    logic [43:0]  spr_x;
    logic [43:0]  spr_y;
    logic [63:0]  spr_base;
    logic [15:0]  rom_addr;
    logic         rom_en;
    logic [7:0]   mem_value;
    logic [2:0]   r;
    logic [2:0]   g;
    logic [1:0]   b;
    logic         fetch_busy;
    logic         overrun;

    sprite_line_sched #(
        .NUM_SPR(NUM_SPR), .SPR_W(32), .SPR_H(32), .ROM_STRIDE(500)
    ) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_vc(next_vc),
        .hc(hc), .blank(blank), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_base(spr_base), .rom_addr(rom_addr), .rom_en(rom_en),
        .mem_value(mem_value), .R(r), .G(g), .B(b),
        .fetch_busy(fetch_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // ROM contents: mode 0 = low address byte; mode 1 = slot-0 area has
    // 8'h11 at even / 8'h00 at odd addresses, area from 16'h4000 is 8'h22.
    int rom_mode = 0;

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        if (rom_mode == 0) return a[7:0];
        if (a < 16'h4000)  return a[0] ? 8'h00 : 8'h11;
        return 8'h22;
    endfunction

    logic [15:0] addr_q[$];
    int          rom_en_cnt = 0;

    always @(posedge clk) begin
        if (rom_en) begin
            mem_value  <= rom_f(rom_addr);
            rom_en_cnt <= rom_en_cnt + 1;
            addr_q.push_back(rom_addr);
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pulse_line(input logic [10:0] vc);
        @(posedge clk); #1;
        line_start = 1'b1;
        next_vc    = vc;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    // Cycles from the sampling edge of line_start until fetch_busy drops
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (fetch_busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_line(input logic [10:0] vc, output int cyc);
        pulse_line(vc);
        wait_idle(cyc);
    endtask

    // Drive one pixel, read the registered colour a cycle later
    task automatic show(input string name, input logic [10:0] h, input logic bl, input logic [7:0] exp);
        @(posedge clk); #1;
        hc    = h;
        blank = bl;
        @(posedge clk); #1;
        check(name, {r, g, b}, exp);
        blank = 1'b1;
    endtask

    typedef struct {
        int          ph;
        logic [10:0] hc;
        logic        blank;
        logic [7:0]  exp;
    } pix_vec_t;

    pix_vec_t vecs[$];

    task automatic run_table(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].ph == ph) begin
                show($sformatf("pix_p%0d_hc%0d_b%0d", ph, vecs[i].hc, vecs[i].blank),
                     vecs[i].hc, vecs[i].blank, vecs[i].exp);
            end
        end
    endtask

    task automatic set_slot(input int s, input logic [10:0] x, input logic [10:0] y, input logic [15:0] base);
        spr_x[s*11 +: 11]    = x;
        spr_y[s*11 +: 11]    = y;
        spr_base[s*16 +: 16] = base;
    endtask

    initial begin
        int cyc;

        // Single sprite at x=100, row 2 (addresses 1000..1031), low-byte ROM
        vecs.push_back('{0, 11'd100, 1'b0, 8'hE8});
        vecs.push_back('{0, 11'd101, 1'b0, 8'hE9});
        vecs.push_back('{0, 11'd110, 1'b0, 8'hF2});
        vecs.push_back('{0, 11'd123, 1'b0, 8'hFF});
        vecs.push_back('{0, 11'd124, 1'b0, 8'h00});   // address 1024 -> transparent
        vecs.push_back('{0, 11'd131, 1'b0, 8'h07});
        vecs.push_back('{0, 11'd99,  1'b0, 8'h00});
        vecs.push_back('{0, 11'd132, 1'b0, 8'h00});
        vecs.push_back('{0, 11'd110, 1'b1, 8'h00});   // blanked
        // Slots 0 and 1 stacked: slot 0 even columns 8'h11, odd transparent
        vecs.push_back('{1, 11'd100, 1'b0, 8'h11});
        vecs.push_back('{1, 11'd101, 1'b0, 8'h22});
        vecs.push_back('{1, 11'd130, 1'b0, 8'h11});
        vecs.push_back('{1, 11'd131, 1'b0, 8'h22});
        vecs.push_back('{1, 11'd132, 1'b0, 8'h00});

        rst        = 1'b1;
        line_start = 1'b0;
        next_vc    = '0;
        hc         = '0;
        blank      = 1'b1;
        spr_en     = '0;
        spr_x      = '0;
        spr_y      = '0;
        spr_base   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_en",     {31'd0, rom_en}, 32'd0);
        check("rst_rom_addr",   {16'd0, rom_addr}, 32'd0);
        check("rst_rgb",        {24'd0, r, g, b}, 32'd0);
        check("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
        check("rst_overrun",    {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // No sprites enabled: 2 cycles per skipped slot, no ROM traffic
        rom_en_cnt = 0;
        do_line(11'd10, cyc);
        check("skip_cycles", cyc, 32'd8);
        check("skip_no_rom", rom_en_cnt, 32'd0);
        show("skip_pixel", 11'd100, 1'b0, 8'h00);

        // One visible sprite: addresses 1000..1031, cost 35 + 3*2 cycles
        rom_mode = 0;
        spr_en   = 4'b0001;
        set_slot(0, 11'd100, 11'd50, 16'd0);
        addr_q.delete();
        do_line(11'd52, cyc);
        check("one_cycles", cyc, 32'd41);
        check("one_addr_cnt", addr_q.size(), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("one_addr_%0d", i),
                  (i < addr_q.size()) ? {16'd0, addr_q[i]} : 32'hFFFF_FFFF, 32'(1000 + i));
        end
        do_line(11'd53, cyc);
        run_table(0);

        // Two stacked slots with different data: priority and transparency
        rom_mode = 1;
        spr_en   = 4'b0011;
        set_slot(1, 11'd100, 11'd50, 16'h4000);
        do_line(11'd52, cyc);
        check("two_cycles", cyc, 32'd74);
        do_line(11'd53, cyc);
        run_table(1);

        // Vertical boundaries: line y+SPR_H is outside, y+SPR_H-1 is row 31
        rom_mode   = 0;
        spr_en     = 4'b0001;
        rom_en_cnt = 0;
        do_line(11'd82, cyc);
        check("below_no_rom", rom_en_cnt, 32'd0);
        addr_q.delete();
        do_line(11'd81, cyc);
        check("row31_cnt",   addr_q.size(), 32'd32);
        check("row31_first", (addr_q.size() > 0)  ? {16'd0, addr_q[0]}  : 32'hFFFF_FFFF, 32'd15500);
        check("row31_last",  (addr_q.size() > 31) ? {16'd0, addr_q[31]} : 32'hFFFF_FFFF, 32'd15531);
        do_line(11'd0, cyc);
        show("row31_pix0",  11'd100, 1'b0, 8'h8C);
        show("row31_pix31", 11'd131, 1'b0, 8'hAB);
        do_line(11'd1, cyc);
        show("empty_line", 11'd100, 1'b0, 8'h00);

        // Overrun: second line_start 40 cycles in, while slot 1 is fetching
        check("pre_overrun", {31'd0, overrun}, 32'd0);
        spr_en = 4'b1111;
        set_slot(1, 11'd200, 11'd50, 16'h1000);
        set_slot(2, 11'd300, 11'd50, 16'h2000);
        set_slot(3, 11'd400, 11'd50, 16'h3000);
        pulse_line(11'd52);
        repeat (38) @(posedge clk);
        pulse_line(11'd53);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_idle(cyc);
        check("full_cycles", cyc, 32'd140);
        show("abort_slot0", 11'd100, 1'b0, 8'hE8);
        show("abort_slot1", 11'd200, 1'b0, 8'h00);
        show("abort_slot2", 11'd300, 1'b0, 8'h00);
        show("abort_slot3", 11'd400, 1'b0, 8'h00);
        do_line(11'd54, cyc);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        show("full_slot1", 11'd200, 1'b0, 8'hDC);
        show("full_slot3", 11'd400, 1'b0, 8'hDC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
